uart_driver: RTL and testbench

UART_DRIVER -- requirements
Module: uart_driver

---
 rtl/uart_driver_pkg.sv | 7 +
 rtl/uart_sync2.sv | 14 +
 rtl/uart_driver.sv | 102 ++++++++++
 tb/tb_uart_driver.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_driver_pkg.sv
// uart_driver_pkg: shared UART state encodings and frame constants
package uart_driver_pkg;
   localparam int OVERSAMPLE_DEFAULT = 16;
   localparam int DATA_BITS = 8;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer with configurable reset value
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clock)
      if (reset) {q, meta} <= {RESET_VAL, RESET_VAL};
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_driver.sv
// uart_driver: oversampled 8N1 UART transmitter and receiver with ready/valid byte ports
module uart_driver
   import uart_driver_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
   parameter int DATA_BITS = uart_driver_pkg::DATA_BITS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_uart_clock,
   input  logic                 io_uart_reset,
   input  logic                 io_uart_rx_serial,
   input  logic                 io_uart_rx_data_ready,
   output logic                 io_uart_rx_data_valid,
   output logic [DATA_BITS-1:0] io_uart_rx_data_bits_tdata,
   output logic                 io_uart_tx_serial,
   output logic                 io_uart_tx_data_ready,
   input  logic                 io_uart_tx_data_valid,
   input  logic [DATA_BITS-1:0] io_uart_tx_data_bits_tdata
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   logic rst, uclk_s, uclk_d, tick, rx_s;
   assign rst = reset | io_uart_reset;
   uart_sync2 #(.RESET_VAL(1'b0)) u_sync_clk (.clock(clock), .reset(rst), .d(io_uart_clock), .q(uclk_s));
   uart_sync2 #(.RESET_VAL(1'b1)) u_sync_rx (.clock(clock), .reset(rst), .d(io_uart_rx_serial), .q(rx_s));
   always_ff @(posedge clock) uclk_d <= rst ? 1'b0 : uclk_s;
   assign tick = uclk_s & ~uclk_d;
   tx_state_t tx_st, tx_nx;
   logic [CW-1:0] tx_cnt;
   logic [BW-1:0] tx_bit;
   logic [DATA_BITS-1:0] tx_shift;
   logic tx_bit_end;
   assign tx_bit_end = tick && tx_cnt == LAST;
   always_ff @(posedge clock) tx_st <= rst ? TX_IDLE : tx_nx;
   always_ff @(posedge clock)
      if (rst) begin
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_shift <= '0;
      end else begin
         tx_cnt <= (tx_nx != tx_st || tx_bit_end) ? '0 : tx_cnt + CW'(tick);
         tx_bit <= tx_st != TX_DATA ? '0 : tx_bit + BW'(tx_bit_end);
         if (io_uart_tx_data_ready && io_uart_tx_data_valid) tx_shift <= io_uart_tx_data_bits_tdata;
      end
   always_comb begin
      tx_nx = tx_st;
      case (tx_st)
         TX_IDLE:  if (io_uart_tx_data_valid) tx_nx = TX_START;
         TX_START: if (tx_bit_end) tx_nx = TX_DATA;
         TX_DATA:  if (tx_bit_end && tx_bit == LAST_BIT) tx_nx = TX_STOP;
         default:  if (tx_bit_end) tx_nx = TX_IDLE;
      endcase
   end
   always_comb begin
      io_uart_tx_data_ready = tx_st == TX_IDLE && !rst;
      io_uart_tx_serial = rst || (tx_st == TX_DATA ? tx_shift[tx_bit] : tx_st != TX_START);
   end
   rx_state_t rx_st, rx_nx;
   logic [CW-1:0] rx_cnt;
   logic [BW-1:0] rx_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic rx_bit_end, rx_half, deliver;
   assign rx_bit_end = tick && rx_cnt == LAST;
   assign rx_half = tick && rx_cnt == HALF;
   always_ff @(posedge clock) rx_st <= rst ? RX_IDLE : rx_nx;
   always_ff @(posedge clock)
      if (rst) begin
         rx_cnt <= '0;
         rx_bit <= '0;
         rx_shift <= '0;
      end else begin
         rx_cnt <= (rx_nx != rx_st || rx_bit_end) ? '0 : rx_cnt + CW'(tick);
         rx_bit <= rx_st != RX_DATA ? '0 : rx_bit + BW'(rx_bit_end);
         if (rx_st == RX_DATA && rx_bit_end) rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
      end
   always_comb begin
      rx_nx = rx_st;
      case (rx_st)
         RX_IDLE:  if (tick && !rx_s) rx_nx = RX_START;
         RX_START: if (rx_half) rx_nx = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_bit_end && rx_bit == LAST_BIT) rx_nx = RX_STOP;
         RX_STOP:  if (rx_bit_end) rx_nx = rx_s ? RX_IDLE : RX_WAIT_HIGH;
         default:  if (rx_s) rx_nx = RX_IDLE;
      endcase
   end
   assign deliver = rx_st == RX_STOP && rx_bit_end && rx_s;
   // an overrun (held byte not yet taken) drops the newly received byte
   always_ff @(posedge clock)
      if (rst) begin
         io_uart_rx_data_valid <= 1'b0;
         io_uart_rx_data_bits_tdata <= '0;
      end else if (deliver && (!io_uart_rx_data_valid || io_uart_rx_data_ready)) begin
         io_uart_rx_data_valid <= 1'b1;
         io_uart_rx_data_bits_tdata <= rx_shift;
      end else if (io_uart_rx_data_valid && io_uart_rx_data_ready) begin
         io_uart_rx_data_valid <= 1'b0;
      end
endmodule

// File: tb/tb_uart_driver.sv
// tb_uart_driver: directed self-checking bench for uart_driver (bit period = 64 clocks)
module tb_uart_driver;
   logic clock = 0, reset = 1, uclk = 0, uart_rst = 0, rx_drv = 1, loop = 0;
   logic rx_ready = 0, tx_valid = 0, rdy_bad = 0, ser_bad = 0;
   logic [7:0] tx_data = 0, vdata = 0, rx_data;
   logic rx_valid, tx_serial, tx_ready;
   int tests = 0, fails = 0, vcount = 0, n, c0;
   always #5 clock = ~clock;
   always #20 uclk = ~uclk;
   uart_driver dut (
      .clock(clock), .reset(reset), .io_uart_clock(uclk), .io_uart_reset(uart_rst),
      .io_uart_rx_serial(loop ? tx_serial : rx_drv), .io_uart_rx_data_ready(rx_ready),
      .io_uart_rx_data_valid(rx_valid), .io_uart_rx_data_bits_tdata(rx_data),
      .io_uart_tx_serial(tx_serial), .io_uart_tx_data_ready(tx_ready),
      .io_uart_tx_data_valid(tx_valid), .io_uart_tx_data_bits_tdata(tx_data)
   );
   always @(negedge clock)
      if (rx_valid) begin
         vcount = vcount + 1;
         vdata = rx_data;
      end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic run_len(input logic v, output int len);
      len = 0;
      while (tx_serial === v && len < 1000) begin
         if (tx_ready) rdy_bad = 1;
         @(negedge clock);
         len++;
      end
   endtask
   task automatic wait_ready();
      int k = 0;
      while (!tx_ready && k < 3000) begin
         @(negedge clock);
         k++;
      end
      check("tx_ready_wait", k < 3000, 1);
   endtask
   task automatic send_tx(input logic [7:0] b);
      wait_ready();
      tx_data = b;
      tx_valid = 1;
      @(negedge clock);
      tx_valid = 0;
   endtask
   task automatic send_rx(input logic [7:0] b, input logic stop, input logic after);
      rx_drv = 0;
      repeat (64) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (64) @(negedge clock);
      end
      rx_drv = stop;
      repeat (64) @(negedge clock);
      rx_drv = after;
   endtask
   task automatic check_tx_frame(input string tag, input logic [7:0] b);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      repeat (32) @(negedge clock);
      for (int k = 0; k < 10; k++) begin
         if (tx_serial !== bits[k]) ser_bad = 1;
         if (k < 9) repeat (64) @(negedge clock);
      end
      check(tag, ser_bad, 0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   initial begin
      repeat (4) @(negedge clock);
      check("rst_serial", tx_serial, 1);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 8'h00);
      reset = 0;
      @(negedge clock);
      check("ready_after_rst", tx_ready, 1);
      // 0x55: exact run lengths; a second offer during the frame must be ignored
      tx_data = 8'h55;
      tx_valid = 1;
      @(negedge clock);
      tx_data = 8'hFF;
      check("ready_drop", tx_ready, 0);
      run_len(0, n);
      tx_valid = 0;
      check("start_len", n >= 61 && n <= 64, 1);
      for (int i = 1; i <= 8; i++) begin
         run_len(i[0], n);
         check("data_len", n, 64);
      end
      n = 0;
      while (!tx_ready && n < 200) begin
         if (tx_serial !== 1) ser_bad = 1;
         @(negedge clock);
         n++;
      end
      check("stop_len", n, 64);
      check("stop_level", ser_bad, 0);
      check("ready_low_frame", rdy_bad, 0);
      // loopback 0xA3
      loop = 1;
      rx_ready = 1;
      c0 = vcount;
      send_tx(8'hA3);
      wait_ready();
      repeat (20) @(negedge clock);
      check("lb_count", vcount - c0, 1);
      check("lb_data", vdata, 8'hA3);
      loop = 0;
      // overrun: 0x7E dropped while 0x3C is held
      rx_ready = 0;
      repeat (20) @(negedge clock);
      send_rx(8'h3C, 1, 1);
      repeat (10) @(negedge clock);
      check("ovr_valid1", rx_valid, 1);
      check("ovr_data1", rx_data, 8'h3C);
      send_rx(8'h7E, 1, 1);
      repeat (10) @(negedge clock);
      check("ovr_valid2", rx_valid, 1);
      check("ovr_data2", rx_data, 8'h3C);
      rx_ready = 1;
      @(negedge clock);
      rx_ready = 0;
      check("ovr_clear", rx_valid, 0);
      // 4-tick glitch is rejected
      rx_ready = 1;
      c0 = vcount;
      rx_drv = 0;
      repeat (16) @(negedge clock);
      rx_drv = 1;
      repeat (200) @(negedge clock);
      check("glitch_count", vcount - c0, 0);
      check("glitch_valid", rx_valid, 0);
      // framing error, line held low, then 0x11
      c0 = vcount;
      send_rx(8'h00, 0, 0);
      repeat (300) @(negedge clock);
      check("frame_drop", vcount - c0, 0);
      rx_drv = 1;
      repeat (20) @(negedge clock);
      send_rx(8'h11, 1, 1);
      repeat (20) @(negedge clock);
      check("frame_next_count", vcount - c0, 1);
      check("frame_next_data", vdata, 8'h11);
      // reset during data bit 3 of 0x00
      send_tx(8'h00);
      repeat (288) @(negedge clock);
      check("pre_rst_serial", tx_serial, 0);
      uart_rst = 1;
      @(negedge clock);
      check("mid_rst_serial", tx_serial, 1);
      check("mid_rst_ready", tx_ready, 0);
      uart_rst = 0;
      @(negedge clock);
      check("post_rst_ready", tx_ready, 1);
      ser_bad = 0;
      send_tx(8'hF0);
      check_tx_frame("tx_f0_frame", 8'hF0);
      ser_bad = 0;
      send_tx(8'h3A);
      check_tx_frame("tx_3a_frame", 8'h3A);
      wait_ready();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
